// File: rtl/fpalu_seq_pkg.sv
// fpalu_seq_pkg: state encoding and constants shared by the FP ALU issue sequencer
package fpalu_seq_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, BUSY, RESP} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;
    localparam logic [31:0] QNAN_ABORT = 32'h7FC0_0000;
endpackage

// File: rtl/fpalu_seq_timeout.sv
// fpalu_seq_timeout: watchdog counter, cleared while idle, counts while an op is outstanding
module fpalu_seq_timeout
    import fpalu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer;
    assign expire = timer == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) timer <= '0;
        else if (clear) timer <= '0;
        else if (enable) timer <= timer + 1'b1;
    end
endmodule

// File: rtl/fpalu_issue_seq.sv
// fpalu_issue_seq: issues add/mul commands to the fpalu and returns result/flow or a watchdog abort.
// Define FPALU_SEQ_STATS_EN to add saturating op/overflow/timeout counters.
module fpalu_issue_seq
    import fpalu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
`ifdef FPALU_SEQ_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_op,
    output logic             alu_start,
    input  logic [31:0]      alu_result,
    input  logic             alu_flow,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_flow,
`ifdef FPALU_SEQ_STATS_EN
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_flow,
    output logic [CNT_W-1:0] stat_tmo,
`endif
    output logic             rsp_timeout
);
    state_t state;
    logic   active;
    logic   capture;
    logic   expire;

    assign active  = state == DRAIN || state == BUSY;
    assign capture = state == BUSY && alu_done;

    fpalu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (active),
        .expire (expire)
    );

    // DRAIN waits for a stale done to fall so only a fresh done edge is captured in BUSY
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_ADD;
            alu_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flow    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    alu_a     <= cmd_a;
                    alu_b     <= cmd_b;
                    alu_op    <= cmd_op;
                    alu_start <= 1'b1;
                    cmd_ready <= 1'b0;
                    state     <= DRAIN;
                end
                DRAIN, BUSY: if (capture || expire) begin
                    rsp_result  <= capture ? alu_result : QNAN_ABORT;
                    rsp_flow    <= capture && alu_flow;
                    rsp_timeout <= !capture;
                    alu_start   <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end else if (state == DRAIN && !alu_done) begin
                    state <= BUSY;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPALU_SEQ_STATS_EN
    logic accept;
    logic abort;
    assign accept = state == IDLE && cmd_valid;
    assign abort  = active && expire && !capture;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_ops  <= '0;
            stat_flow <= '0;
            stat_tmo  <= '0;
        end else begin
            if (accept) stat_ops <= stat_ops + {{(CNT_W-1){1'b0}}, ~&stat_ops};
            if (capture && alu_flow) stat_flow <= stat_flow + {{(CNT_W-1){1'b0}}, ~&stat_flow};
            if (abort) stat_tmo <= stat_tmo + {{(CNT_W-1){1'b0}}, ~&stat_tmo};
        end
    end
`endif
endmodule

// File: tb/tb_fpalu_issue_seq.sv
// tb_fpalu_issue_seq: directed and randomized checks of the fpalu issue sequencer against a cycle-count model
module tb_fpalu_issue_seq;
    localparam int T = 8;
    localparam logic [31:0] QN = 32'h7FC0_0000;

    logic clock = 1'b0, reset = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [31:0] alu_a, alu_b, alu_result = '0, rsp_result;
    logic alu_op, alu_start, alu_flow = 1'b0, alu_done = 1'b0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_flow, rsp_timeout;
`ifdef FPALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_flow, stat_tmo;
`endif
    int checks = 0, errors = 0;
    int n_flow = 0, n_tmo = 0;

    fpalu_issue_seq #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flow(alu_flow), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flow(rsp_flow),
`ifdef FPALU_SEQ_STATS_EN
        .stat_ops(stat_ops), .stat_flow(stat_flow), .stat_tmo(stat_tmo),
`endif
        .rsp_timeout(rsp_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model ALU: done held high for s cycles after issue (stale), then low, then rises at cycle s+1+lat
    task automatic run_op(input logic [31:0] a, b, input logic op, input int s, lat,
                          input logic [31:0] res, input logic flow, input int bp, input bit hold,
                          output int rc, output logic [31:0] oa, ob, output logic oop, ost,
                          output logic [31:0] rres, output logic rflow, rtmo, output bit stable,
                          output logic sa, va, ra);
        int n, p;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin step(); n++; end
        step();
        oa = alu_a; ob = alu_b; oop = alu_op; ost = alu_start;
        if (hold) begin cmd_a = ~a; cmd_b = ~b; cmd_op = ~op; end
        else cmd_valid = 1'b0;
        if (!alu_done) s = 0;
        p = s + 1 + lat;
        rc = -1;
        stable = 1'b1;
        for (int k = 1; k <= 200 && rc < 0; k++) begin
            if (k == p) begin alu_result = res; alu_flow = flow; end
            alu_done = (k <= s) || (k >= p);
            step();
            if (rsp_valid === 1'b1) rc = k;
            else if (cmd_ready !== 1'b0 || alu_a !== a || alu_start !== 1'b1) stable = 1'b0;
        end
        rres = rsp_result; rflow = rsp_flow; rtmo = rsp_timeout; sa = alu_start;
        rsp_ready = 1'b0;
        for (int j = 0; j < bp; j++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_result !== rres || rsp_flow !== rflow ||
                rsp_timeout !== rtmo || cmd_ready !== 1'b0 || alu_a !== a) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        va = rsp_valid; ra = cmd_ready;
    endtask

    task automatic test_reset();
        checks++; if ({cmd_ready, alu_start, rsp_valid} !== 3'b100) begin errors++; $display("FAIL reset_hold_ctrl got %b exp 100", {cmd_ready, alu_start, rsp_valid}); end
        reset = 1'b1;
        step();
        checks++; if ({cmd_ready, alu_start, alu_op, rsp_valid, rsp_flow, rsp_timeout} !== 6'b100000) begin errors++; $display("FAIL reset_flags got %b exp 100000", {cmd_ready, alu_start, alu_op, rsp_valid, rsp_flow, rsp_timeout}); end
        checks++; if ({alu_a, alu_b, rsp_result} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", alu_a, alu_b, rsp_result); end
`ifdef FPALU_SEQ_STATS_EN
        checks++; if ({stat_ops, stat_flow, stat_tmo} !== 48'd0) begin errors++; $display("FAIL reset_stats got %h exp 0", {stat_ops, stat_flow, stat_tmo}); end
`endif
    endtask

    task automatic test_add();
        int rc; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h3F800000, 32'h40000000, 1'b0, 0, 3, 32'h40400000, 1'b0, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if ({oa, ob} !== {32'h3F800000, 32'h40000000}) begin errors++; $display("FAIL add_operands got %h %h exp 3f800000 40000000", oa, ob); end
        checks++; if ({oop, ost} !== 2'b01) begin errors++; $display("FAIL add_op_start got %b exp 01", {oop, ost}); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL add_latency got %0d exp 4", rc); end
        checks++; if ({rres, rflow, rtmo} !== {32'h40400000, 2'b00}) begin errors++; $display("FAIL add_rsp got %h %b %b exp 40400000 0 0", rres, rflow, rtmo); end
        checks++; if ({sa, va, ra, stb} !== 4'b0011) begin errors++; $display("FAIL add_handshake got %b exp 0011", {sa, va, ra, stb}); end
    endtask

    task automatic test_stale_mul();
        int rc; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h40000000, 32'h40400000, 1'b1, 3, 2, 32'h40C00000, 1'b0, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if (oop !== 1'b1) begin errors++; $display("FAIL mul_op got %b exp 1", oop); end
        checks++; if (rc !== 6) begin errors++; $display("FAIL stale_latency got %0d exp 6", rc); end
        checks++; if ({rres, rflow, rtmo} !== {32'h40C00000, 2'b00}) begin errors++; $display("FAIL stale_rsp got %h %b %b exp 40c00000 0 0", rres, rflow, rtmo); end
    endtask

    task automatic test_overflow();
        int rc; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h7F7FFFFF, 32'h40000000, 1'b1, 1, 2, 32'h7F800000, 1'b1, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if ({rc, rres, rflow, rtmo} !== {32'd4, 32'h7F800000, 2'b10}) begin errors++; $display("FAIL ovf_rsp got %0d %h %b %b exp 4 7f800000 1 0", rc, rres, rflow, rtmo); end
`ifdef FPALU_SEQ_STATS_EN
        checks++; if (stat_flow !== 16'd1) begin errors++; $display("FAIL ovf_stat got %0d exp 1", stat_flow); end
`endif
    endtask

    task automatic test_timeout();
        int rc; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 2, 1000, 32'h0, 1'b0, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if (rc !== T) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", rc, T); end
        checks++; if ({rres, rflow, rtmo, sa} !== {QN, 3'b010}) begin errors++; $display("FAIL tmo_rsp got %h %b %b start %b exp 7fc00000 0 1 0", rres, rflow, rtmo, sa); end
        checks++; if ({va, ra} !== 2'b01) begin errors++; $display("FAIL tmo_release got %b exp 01", {va, ra}); end
    endtask

    task automatic test_boundary();
        int rc; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h11111111, 32'h22222222, 1'b0, 0, T - 1, 32'h33333333, 1'b1, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if ({rc, rres, rflow, rtmo} !== {T, 32'h33333333, 2'b10}) begin errors++; $display("FAIL done_wins got %0d %h %b %b exp %0d 33333333 1 0", rc, rres, rflow, rtmo, T); end
        run_op(32'h44444444, 32'h55555555, 1'b1, 0, T, 32'h66666666, 1'b0, 0, 1'b0,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if ({rc, rres, rflow, rtmo} !== {T, QN, 2'b01}) begin errors++; $display("FAIL late_done got %0d %h %b %b exp %0d 7fc00000 0 1", rc, rres, rflow, rtmo, T); end
    endtask

    task automatic test_backpressure();
        int rc, k; logic [31:0] oa, ob, rres; logic oop, ost, rflow, rtmo, sa, va, ra; bit stb;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 2, 32'h40000000, 1'b0, 5, 1'b1,
               rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", stb); end
        checks++; if ({rc, rres} !== {32'd3, 32'h40000000}) begin errors++; $display("FAIL bp_rsp got %0d %h exp 3 40000000", rc, rres); end
        checks++; if ({va, ra, alu_a} !== {2'b01, 32'h3F800000}) begin errors++; $display("FAIL bp_no_early_accept got %b %b %h exp 0 1 3f800000", va, ra, alu_a); end
        step();
        cmd_valid = 1'b0;
        checks++; if ({alu_a, alu_start, cmd_ready} !== {32'hC07FFFFF, 2'b10}) begin errors++; $display("FAIL bp_next_accept got %h %b %b exp c07fffff 1 0", alu_a, alu_start, cmd_ready); end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin step(); k++; end
        checks++; if ({k, rsp_timeout, rsp_result} !== {T, 1'b1, QN}) begin errors++; $display("FAIL stuck_done_abort got %0d %b %h exp %0d 1 7fc00000", k, rsp_timeout, rsp_result, T); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        cmd_a = 32'h12345678; cmd_b = 32'h9ABCDEF0; cmd_op = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        alu_done = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        checks++; if ({cmd_ready, alu_start, rsp_valid, alu_a} !== {3'b100, 32'h0}) begin errors++; $display("FAIL rst_async got %b%b%b %h exp 100 0", cmd_ready, alu_start, rsp_valid, alu_a); end
        #3 reset = 1'b1;
        step();
        checks++; if ({cmd_ready, alu_start, rsp_valid, alu_op, alu_b} !== {4'b1000, 32'h0}) begin errors++; $display("FAIL rst_idle got %b%b%b%b %h exp 1000 0", cmd_ready, alu_start, rsp_valid, alu_op, alu_b); end
`ifdef FPALU_SEQ_STATS_EN
        checks++; if ({stat_ops, stat_flow, stat_tmo} !== 48'd0) begin errors++; $display("FAIL rst_stats got %h exp 0", {stat_ops, stat_flow, stat_tmo}); end
`endif
    endtask

    task automatic test_random();
        int rc, s, lat, p, bp, exp_rc; logic [31:0] a, b, res, oa, ob, rres, exp_res;
        logic op, flow, oop, ost, rflow, rtmo, sa, va, ra, tmo, exp_flow; bit stb;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; res = $urandom; op = 1'($urandom); flow = 1'($urandom);
            s = alu_done ? int'($urandom_range(0, 4)) : 0;
            lat = int'($urandom_range(1, 9));
            bp = int'($urandom_range(0, 3));
            p = s + 1 + lat;
            tmo = p > T;
            exp_rc = tmo ? T : p;
            exp_res = tmo ? QN : res;
            exp_flow = !tmo && flow;
            n_flow += int'(exp_flow);
            n_tmo += int'(tmo);
            run_op(a, b, op, s, lat, res, flow, bp, 1'b0,
                   rc, oa, ob, oop, ost, rres, rflow, rtmo, stb, sa, va, ra);
            checks++; if ({oa, ob, oop, ost} !== {a, b, op, 1'b1}) begin errors++; $display("FAIL rnd%0d_issue got %h %h %b %b exp %h %h %b 1", i, oa, ob, oop, ost, a, b, op); end
            checks++; if (rc !== exp_rc) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, rc, exp_rc); end
            checks++; if ({rres, rflow, rtmo} !== {exp_res, exp_flow, tmo}) begin errors++; $display("FAIL rnd%0d_rsp got %h %b %b exp %h %b %b", i, rres, rflow, rtmo, exp_res, exp_flow, tmo); end
            checks++; if ({stb, sa, va, ra} !== 4'b1001) begin errors++; $display("FAIL rnd%0d_ctrl got %b exp 1001", i, {stb, sa, va, ra}); end
        end
`ifdef FPALU_SEQ_STATS_EN
        checks++; if ({stat_ops, stat_flow, stat_tmo} !== {16'd24, 16'(n_flow), 16'(n_tmo)}) begin errors++; $display("FAIL rnd_stats got %0d %0d %0d exp 24 %0d %0d", stat_ops, stat_flow, stat_tmo, n_flow, n_tmo); end
`endif
    endtask

    initial begin
        repeat (2) step();
        test_reset();
        test_add();
        test_stale_mul();
        test_overflow();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpalu_issue_seq.md
Name: fpalu_issue_seq

Overview:
- Initiator side of the FP ALU operand/result interface.
- Accepts add/mul commands over a valid/ready handshake and drives operands, op and start onto the fpalu.
- Waits for a fresh done edge, captures result/flow and returns them over a valid/ready response channel.
- Watchdog aborts hung operations. Sits between the instruction/control front end and the fpalu.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in DRAIN+BUSY before abort; legal range 4..65535.
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  32  IEEE-754 single operand A.
- cmd_b  in  32  IEEE-754 single operand B.
- cmd_op  in  1  0 = add, 1 = mul.
- alu_a  out  32  operand A to the fpalu.
- alu_b  out  32  operand B to the fpalu.
- alu_op  out  1  op select to the fpalu.
- alu_start  out  1  high while an operation is outstanding.
- alu_result  in  32  fpalu registered result.
- alu_flow  in  1  fpalu overflow flag.
- alu_done  in  1  fpalu done (level; may stay high from the previous op).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_flow  out  1  captured overflow.
- rsp_timeout  out  1  response produced by watchdog abort.
- stat_ops  out  CNT_W  only when FPALU_SEQ_STATS_EN is defined.
- stat_flow  out  CNT_W  only when FPALU_SEQ_STATS_EN is defined.
- stat_tmo  out  CNT_W  only when FPALU_SEQ_STATS_EN is defined.

Behaviour:
- Reset (reset low, async): state=IDLE; cmd_ready=1; alu_a, alu_b, alu_op, alu_start = 0; rsp_valid, rsp_result, rsp_flow, rsp_timeout = 0; timer=0; stats=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: register cmd_a, cmd_b, cmd_op into alu_a, alu_b, alu_op; set alu_start=1; timer=0; next state DRAIN.
- DRAIN:
  - cmd_ready=0; operands held stable.
  - Done-edge rule: a done that was already high when the op was issued is never accepted.
  - alu_done=0 -> BUSY.
  - alu_done=1 -> stay in DRAIN.
- BUSY:
  - alu_done=1 -> capture alu_result and alu_flow into rsp_result and rsp_flow; rsp_timeout=0; alu_start=0; rsp_valid=1; next state RESP.
- Timer:
  - Increments every cycle in DRAIN or BUSY.
  - When timer == TIMEOUT_CYCLES-1 with no capture that cycle: rsp_result=32'h7FC00000 (qNaN); rsp_flow=0; rsp_timeout=1; alu_start=0; rsp_valid=1; next state RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid held, with rsp_result, rsp_flow and rsp_timeout stable, until rsp_ready=1.
  - On acceptance: rsp_valid=0; next state IDLE.
  - cmd_ready stays 0 in RESP; a new command is accepted only in the cycle after the response handshake.
- Latency:
  - Command accept to alu_start: 1 cycle.
  - alu_done rising to rsp_valid: 1 cycle.
  - Minimum command-to-response: 3 cycles plus fpalu latency.
- Throughput: at most one outstanding operation.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, in-flight op discarded.
- cmd_* inputs are ignored when cmd_ready=0.
- alu_* outputs change only in IDLE on command acceptance, except alu_start, which drops on capture or abort.

Optional Feature:
- FPALU_SEQ_STATS_EN defined:
  - Ports stat_ops, stat_flow and stat_tmo exist.
  - stat_ops increments on each command accept.
  - stat_flow increments on each capture with alu_flow=1.
  - stat_tmo increments on each watchdog abort.
  - All three saturate at all-ones and reset to 0.
- Undefined: the three ports and their counters are absent; all other behaviour identical.

Decomposition:
- Package fpalu_seq_pkg:
  - State encoding: IDLE, DRAIN, BUSY, RESP.
  - Op constants: OP_ADD=1'b0, OP_MUL=1'b1.
  - Constant QNAN_ABORT=32'h7FC00000.
- One sub-module: fpalu_seq_timeout. Holds the watchdog counter with clear/enable inputs and an expire output.

Test Plan:
- Add, 4-cycle model ALU: cmd_a=3F800000, cmd_b=40000000, cmd_op=0 -> alu_op=0, alu_start=1 one cycle after accept; rsp_result=40400000, rsp_flow=0, rsp_timeout=0.
- Mul with a stale high done left from the add: cmd 40000000 * 40400000, cmd_op=1 -> block waits in DRAIN until done falls, then captures 40C00000 (not the stale 40400000).
- Overflow: 7F7FFFFF * 40000000 -> rsp_flow=1; stat_flow=1 when stats are enabled.
- Hung ALU, done never rises, TIMEOUT_CYCLES=8 -> rsp_valid exactly 8 cycles after alu_start rises; rsp_result=7FC00000, rsp_timeout=1, alu_start=0.
- Backpressure: rsp_ready held low 5 cycles -> response fields stable, cmd_ready=0 throughout; new command accepted only the cycle after the handshake.
- Reset pulsed low while in BUSY -> next cycle shows IDLE, cmd_ready=1, alu_start=0, rsp_valid=0, stats cleared.
